// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style fetch front end.
//   ADDR_W        : byte-address width of the instruction path
//   NOP           : encoding loaded into IF/ID when it is squashed
//   fetch_state_t : fetch FSM states (IDLE, RUN, HALT)
package mips_pkg;

  localparam int ADDR_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter used for the fetch performance counters.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : add one this cycle (ignored once the count is all ones)
//   count : current count value
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// three-state fetch FSM (IDLE / RUN / HALT). HALT is entered when the PC
// leaves the instruction memory and is left only by an in-range redirect.
//
// Build option: define IF_PERF_CNT_EN to enable the stall/flush cycle
// counters; without it the counter outputs are constant zero.
//
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   start                     : run enable, 0 holds fetch
//   pc_wr_i, ifid_wr_i        : hazard-unit write enables (0 = stall/hold)
//   flush_i                   : squash IF/ID contents
//   redirect_i, redirect_pc_i : taken branch/jump and its byte target
//   imem_addr_o, imem_instr_i : combinational instruction-memory port
//   pc_o                      : current PC
//   ifid_pc4_o, ifid_instr_o, ifid_valid_o : IF/ID register contents
//   stall_cnt_o, flush_cnt_o  : performance counters
module if_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                IMEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_wr_i,
  input  logic              ifid_wr_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  output logic [31:0]       ifid_instr_o,
  output logic              ifid_valid_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  // One past the last valid byte address; one bit wider so the
  // comparison also works when the limit is 2^32.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(IMEM_WORDS) << 2;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] ifid_pc4_reg, ifid_pc4_next;
  logic [31:0]       ifid_instr_reg, ifid_instr_next;
  logic              ifid_valid_reg, ifid_valid_next;

  logic [ADDR_W:0]   pc_seq_wide;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] target;
  logic              seq_in_range;
  logic              target_in_range;

  // The carry of pc+4 is kept only for the range test; the PC itself wraps.
  assign pc_seq_wide     = {1'b0, pc_reg} + (ADDR_W+1)'(4);
  assign pc_seq          = pc_seq_wide[ADDR_W-1:0];
  assign target          = redirect_pc_i & ~32'h3;
  assign seq_in_range    = pc_seq_wide < LIMIT;
  assign target_in_range = {1'b0, target} < LIMIT;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_valid_next = ifid_valid_reg;

    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end

      RUN: begin
        if (!start) begin
          state_next = IDLE;
        end else begin
          // PC path: a stall also discards any redirect in the same cycle.
          if (pc_wr_i) begin
            if (redirect_i) begin
              pc_next = target;
              if (!target_in_range) state_next = HALT;
            end else begin
              pc_next = pc_seq;
              if (!seq_in_range) state_next = HALT;
            end
          end
          // IF/ID path: flush wins over a hold request.
          if (flush_i) begin
            ifid_instr_next = NOP;
            ifid_pc4_next   = '0;
            ifid_valid_next = 1'b0;
          end else if (ifid_wr_i) begin
            ifid_instr_next = imem_instr_i;
            ifid_pc4_next   = pc_seq;
            ifid_valid_next = 1'b1;
          end
        end
      end

      HALT: begin
        if (start) begin
          ifid_instr_next = NOP;
          ifid_pc4_next   = '0;
          ifid_valid_next = 1'b0;
          if (pc_wr_i && redirect_i && target_in_range) begin
            pc_next    = target;
            state_next = RUN;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      ifid_pc4_reg   <= '0;
      ifid_instr_reg <= NOP;
      ifid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

  assign pc_o         = pc_reg;
  assign imem_addr_o  = pc_reg;
  assign ifid_pc4_o   = ifid_pc4_reg;
  assign ifid_instr_o = ifid_instr_reg;
  assign ifid_valid_o = ifid_valid_reg;

`ifdef IF_PERF_CNT_EN
  logic run_active;
  assign run_active = (state_reg == RUN) && start;

  sat_cnt #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (run_active && !pc_wr_i),
    .count (stall_cnt_o)
  );

  sat_cnt #(.W(32)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (run_active && flush_i),
    .count (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. Two instances share the stimulus:
// u_a uses the default parameters, u_b starts at 0x3FC to exercise the
// end-of-memory HALT path. Expected outputs are pushed to a scoreboard
// queue before each clock edge and popped/compared after it.
module tb_if_stage;

`ifdef IF_PERF_CNT_EN
  localparam logic [31:0] PERF = 32'd1;
`else
  localparam logic [31:0] PERF = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pc_wr = 1'b1;
  logic        ifid_wr = 1'b1;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] addr_a, instr_a, pc_a, pc4_a, ifid_instr_a, stall_a, flush_cnt_a;
  logic        valid_a;
  logic [31:0] addr_b, instr_b, pc_b, pc4_b, ifid_instr_b, stall_b, flush_cnt_b;
  logic        valid_b;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  assign instr_a = mem_word(addr_a);
  assign instr_b = mem_word(addr_b);

  if_stage u_a (
    .clk(clk), .rst(rst), .start(start), .pc_wr_i(pc_wr), .ifid_wr_i(ifid_wr),
    .flush_i(flush), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(addr_a), .imem_instr_i(instr_a), .pc_o(pc_a),
    .ifid_pc4_o(pc4_a), .ifid_instr_o(ifid_instr_a), .ifid_valid_o(valid_a),
    .stall_cnt_o(stall_a), .flush_cnt_o(flush_cnt_a)
  );

  if_stage #(.RESET_PC(32'h0000_03FC), .IMEM_WORDS(256)) u_b (
    .clk(clk), .rst(rst), .start(start), .pc_wr_i(pc_wr), .ifid_wr_i(ifid_wr),
    .flush_i(flush), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(addr_b), .imem_instr_i(instr_b), .pc_o(pc_b),
    .ifid_pc4_o(pc4_b), .ifid_instr_o(ifid_instr_b), .ifid_valid_o(valid_b),
    .stall_cnt_o(stall_b), .flush_cnt_o(flush_cnt_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t sb[$];
  int   total_checks  = 0;
  int   passed_checks = 0;
  int   txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) passed_checks++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: push expectation, clock, pop and compare.
  task automatic cycle(input bit sel, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic valid,
                       input logic [31:0] stall_n, input logic [31:0] flush_n);
    exp_t e;
    e.pc = pc; e.instr = instr; e.pc4 = pc4; e.valid = valid;
    e.stall = stall_n * PERF; e.flush = flush_n * PERF;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    txn++;
    if (!sel) begin
      $display("txn %0d dut_a pc=%h instr=%h pc4=%h valid=%b stall=%0d flush=%0d",
               txn, pc_a, ifid_instr_a, pc4_a, valid_a, stall_a, flush_cnt_a);
      check("a_pc", pc_a, e.pc);
      check("a_imem_addr", addr_a, e.pc);
      check("a_instr", ifid_instr_a, e.instr);
      check("a_pc4", pc4_a, e.pc4);
      check("a_valid", {31'h0, valid_a}, {31'h0, e.valid});
      check("a_stall_cnt", stall_a, e.stall);
      check("a_flush_cnt", flush_cnt_a, e.flush);
    end else begin
      $display("txn %0d dut_b pc=%h instr=%h pc4=%h valid=%b stall=%0d flush=%0d",
               txn, pc_b, ifid_instr_b, pc4_b, valid_b, stall_b, flush_cnt_b);
      check("b_pc", pc_b, e.pc);
      check("b_imem_addr", addr_b, e.pc);
      check("b_instr", ifid_instr_b, e.instr);
      check("b_pc4", pc4_b, e.pc4);
      check("b_valid", {31'h0, valid_b}, {31'h0, e.valid});
      check("b_stall_cnt", stall_b, e.stall);
      check("b_flush_cnt", flush_cnt_b, e.flush);
    end
  endtask

  task automatic set_defaults();
    pc_wr = 1'b1; ifid_wr = 1'b1; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
  endtask

  initial begin
    logic [31:0] p;

    // Start-up: reset, idle, then run 0, 4, 8.
    rst = 1'b1;
    cycle(0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    start = 1'b1;
    cycle(0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    cycle(0, 32'h4, mem_word(32'h0), 32'h4, 1'b1, 0, 0);
    cycle(0, 32'h8, mem_word(32'h4), 32'h8, 1'b1, 0, 0);

    // Stall with IF/ID hold.
    pc_wr = 1'b0; ifid_wr = 1'b0;
    cycle(0, 32'h8, mem_word(32'h4), 32'h8, 1'b1, 1, 0);
    set_defaults();
    cycle(0, 32'hC, mem_word(32'h8), 32'hC, 1'b1, 1, 0);

    // Redirect with flush; target low bits are cleared.
    redirect = 1'b1; redirect_pc = 32'h22; flush = 1'b1;
    cycle(0, 32'h20, 32'h0, 32'h0, 1'b0, 1, 1);
    set_defaults();
    cycle(0, 32'h24, mem_word(32'h20), 32'h24, 1'b1, 1, 1);

    // Redirect back to 0x10, then a redirect during a stall is dropped.
    redirect = 1'b1; redirect_pc = 32'h10;
    cycle(0, 32'h10, mem_word(32'h24), 32'h28, 1'b1, 1, 1);
    redirect = 1'b1; redirect_pc = 32'h80; pc_wr = 1'b0;
    cycle(0, 32'h10, mem_word(32'h10), 32'h14, 1'b1, 2, 1);
    set_defaults();

    // Flush overrides an IF/ID hold.
    flush = 1'b1; ifid_wr = 1'b0;
    cycle(0, 32'h14, 32'h0, 32'h0, 1'b0, 2, 2);
    set_defaults();

    // start=0 drops to IDLE and holds; start=1 resumes without advancing.
    start = 1'b0;
    cycle(0, 32'h14, 32'h0, 32'h0, 1'b0, 2, 2);
    cycle(0, 32'h14, 32'h0, 32'h0, 1'b0, 2, 2);
    start = 1'b1;
    cycle(0, 32'h14, 32'h0, 32'h0, 1'b0, 2, 2);

    // Sequential fetch up to 0x40.
    p = 32'h14;
    while (p != 32'h40) begin
      cycle(0, p + 32'h4, mem_word(p), p + 32'h4, 1'b1, 2, 2);
      p = p + 32'h4;
    end

    // Reset mid-run with flush asserted.
    rst = 1'b1; flush = 1'b1;
    cycle(0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    set_defaults();

    // End of memory on the 0x3FC-reset instance.
    start = 1'b0;
    cycle(1, 32'h3FC, 32'h0, 32'h0, 1'b0, 0, 0);
    rst = 1'b0; start = 1'b1;
    cycle(1, 32'h3FC, 32'h0, 32'h0, 1'b0, 0, 0);
    cycle(1, 32'h400, mem_word(32'h3FC), 32'h400, 1'b1, 0, 0);
    cycle(1, 32'h400, 32'h0, 32'h0, 1'b0, 0, 0);
    cycle(1, 32'h400, 32'h0, 32'h0, 1'b0, 0, 0);
    redirect = 1'b1; redirect_pc = 32'h0;
    cycle(1, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    set_defaults();
    cycle(1, 32'h4, mem_word(32'h0), 32'h4, 1'b1, 0, 0);
    cycle(1, 32'h8, mem_word(32'h4), 32'h8, 1'b1, 0, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IMEM_WORDS, default 256, instruction-memory depth in 32-bit words; the valid fetch range is byte addresses 0 to IMEM_WORDS*4-4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  run enable; 0 holds fetch.
REQ-006 pc_wr_i  input  1  hazard unit PC write enable; 0 means stall.
REQ-007 ifid_wr_i  input  1  hazard unit IF/ID write enable; 0 means hold.
REQ-008 flush_i  input  1  squash the IF/ID contents.
REQ-009 redirect_i  input  1  taken branch or jump.
REQ-010 redirect_pc_i  input  32  branch/jump target byte address.
REQ-011 imem_addr_o  output  32  instruction-memory byte address, equal to pc_o.
REQ-012 imem_instr_i  input  32  instruction word, combinational read of imem_addr_o.
REQ-013 pc_o  output  32  current PC.
REQ-014 ifid_pc4_o  output  32  IF/ID latched PC+4.
REQ-015 ifid_instr_o  output  32  IF/ID latched instruction.
REQ-016 ifid_valid_o  output  1  IF/ID holds a real instruction.
REQ-017 stall_cnt_o  output  32  stall cycle count.
REQ-018 flush_cnt_o  output  32  flush cycle count.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and HALT.
REQ-020 IDLE SHALL go to RUN when start=1, and RUN SHALL go to IDLE when start=0; in IDLE the PC, IF/ID register and counters SHALL hold.
REQ-021 In RUN, with pc_wr_i=1 and redirect_i=0, the PC SHALL become pc_o+4, wrapping modulo 2^32.
REQ-022 In RUN, with pc_wr_i=1 and redirect_i=1, the PC SHALL become {redirect_pc_i[31:2],2'b00}.
REQ-023 pc_wr_i=0 SHALL hold the PC and SHALL ignore any simultaneous redirect_i.
REQ-024 The IF/ID register SHALL capture imem_instr_i and pc_o+4 with valid=1 when ifid_wr_i=1, giving one-cycle fetch latency.
REQ-025 flush_i=1 SHALL load instr=32'h0 (NOP), pc4=0 and valid=0, and SHALL override ifid_wr_i=0.
REQ-026 ifid_wr_i=0 without flush_i SHALL hold all IF/ID fields.
REQ-027 RUN SHALL go to HALT when the PC would advance sequentially to IMEM_WORDS*4 or beyond.
REQ-028 In HALT, the PC SHALL hold that out-of-range value and the IF/ID register SHALL load a NOP with valid=0.
REQ-029 HALT SHALL return to RUN when redirect_i=1 with an in-range target.
REQ-030 A redirect while in RUN SHALL NOT change state, except that an out-of-range target SHALL enter HALT.
REQ-031 Input priority SHALL be: rst, then start, then pc_wr_i (for the PC) or flush_i (for IF/ID), then redirect_i / ifid_wr_i.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set: state IDLE, pc_o=RESET_PC, ifid_instr_o=0, ifid_pc4_o=0, ifid_valid_o=0, and both counters 0.
REQ-033 Assertion of rst mid-run SHALL override all other inputs in that cycle.

Configuration
REQ-034 With macro IF_PERF_CNT_EN defined, stall_cnt_o SHALL increment in each RUN cycle with pc_wr_i=0.
REQ-035 With IF_PERF_CNT_EN defined, flush_cnt_o SHALL increment in each RUN cycle with flush_i=1.
REQ-036 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-037 Without IF_PERF_CNT_EN, both counter ports SHALL exist and be tied to 0, with no counter flops.

Structure
REQ-038 The shared package mips_pkg SHALL hold the NOP constant 32'h0, the fetch FSM state enum, and the ADDR_W=32 constant.
REQ-039 The saturating counter SHALL be a single sub-module, sat_cnt, instantiated twice and only under IF_PERF_CNT_EN.

Verification
REQ-040 Scenario, start-up: rst for 2 cycles, start=0 for 3 cycles, then start=1 -> pc_o is 0 while idle, then 0, 4, 8; ifid_instr_o equals mem[0] in the cycle pc_o=4; ifid_valid_o=1.
REQ-041 Scenario, stall: at pc_o=8, drive pc_wr_i=0 and ifid_wr_i=0 for 1 cycle -> pc_o stays 8; IF/ID holds mem[1]; stall_cnt_o=1 (macro defined).
REQ-042 Scenario, redirect with flush: at pc_o=12, drive redirect_i=1, redirect_pc_i=32'h22, flush_i=1 -> next pc_o=32'h20; ifid_instr_o=0; ifid_valid_o=0; flush_cnt_o=1.
REQ-043 Scenario, redirect during stall: drive redirect_i=1 with pc_wr_i=0 at pc_o=16 -> pc_o stays 16; the target is discarded.
REQ-044 Scenario, end of memory: RESET_PC=32'h3FC, IMEM_WORDS=256 -> after fetching 0x3FC the block is in HALT with pc_o=32'h400 and ifid_valid_o=0; redirect to 0x0 resumes fetch at 0x0.
REQ-045 Scenario, reset mid-run: assert rst at pc_o=32'h40 while flush_i=1 -> the next cycle shows reset values on every output.
